// File: rtl/xaui_rx_lane_align.sv
// XAUI receive lane comma aligner: finds the 10-bit comma boundary in a raw SerDes
// stream, re-frames code groups onto it, and tracks lane sync with a LOS/CD/SYNC machine.
module xaui_rx_lane_align #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ERR_LIMIT   = 3
) (
  input  logic       mac_clk,
  input  logic       reset,
  input  logic [9:0] esr_mac_rxd,
  output logic [9:0] aligned_d,
  output logic       comma_det,
  output logic       sync_ok,
  output logic [3:0] align_offset
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned EW = ($clog2(ERR_LIMIT + 1) > 2) ? $clog2(ERR_LIMIT + 1) : 2;

  typedef enum logic [2:0] {StLos, StCd1, StCd2, StCd3, StSync} state_t;

  state_t          state_q, state_d;
  logic [9:0]      rxd_q;
  logic [3:0]      off_q, off_d;
  logic [EW-1:0]   err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  // Older bits at the LSBs; the top input bit never starts or ends a candidate.
  logic [18:0]     win;
  logic [9:0]      cand [10];
  logic [9:0]      match;
  logic            any_hit;
  logic [3:0]      first_k;
  logic            in_phase;

  assign win = {esr_mac_rxd[8:0], rxd_q};

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      cand[k]  = win[k +: 10];
      match[k] = (cand[k][6:0] == 7'b1111100) || (cand[k][6:0] == 7'b0000011);
    end
  end

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    any_hit = 1'b0;
    first_k = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) begin
        any_hit = 1'b1;
        first_k = 4'(k);
      end
    end
  end

  assign in_phase = match[off_q];

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      StLos: begin
        err_d = '0;
        tmo_d = '0;
        if (any_hit) begin
          off_d   = first_k;
          state_d = StCd1;
        end
      end
      StCd1, StCd2, StCd3: begin
        if (in_phase) begin
          state_d = (state_q == StCd1) ? StCd2 : (state_q == StCd2) ? StCd3 : StSync;
        end else if (any_hit) begin
          off_d   = first_k;
          state_d = StCd1;
        end
      end
      StSync: begin
        if (in_phase) begin
          err_d = '0;
          tmo_d = '0;
        end else begin
          if (any_hit && (err_q != EW'(ERR_LIMIT))) err_d = err_q + 1'b1;
          if (tmo_q != TW'(TIMEOUT_CYC - 1)) tmo_d = tmo_q + 1'b1;
          if ((err_d == EW'(ERR_LIMIT)) || (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
            state_d = StLos;
            err_d   = '0;
            tmo_d   = '0;
          end
        end
      end
      default: state_d = StLos;
    endcase
  end

  // Outputs follow next-state values so they line up with the re-framed data.
  always_ff @(posedge mac_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StLos;
      rxd_q        <= '0;
      off_q        <= '0;
      err_q        <= '0;
      tmo_q        <= '0;
      aligned_d    <= '0;
      comma_det    <= 1'b0;
      sync_ok      <= 1'b0;
      align_offset <= '0;
    end else begin
      state_q      <= state_d;
      rxd_q        <= esr_mac_rxd;
      off_q        <= off_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      aligned_d    <= cand[off_d];
      comma_det    <= match[off_d];
      sync_ok      <= (state_d == StSync);
      align_offset <= off_d;
    end
  end

endmodule
